// File: rtl/ricosoc_pkg.sv
// Shared ricosoc iomem definitions: GPIO/PWM register offsets and
// the bus select / byte-lane helpers used by iomem peripherals.
package ricosoc_pkg;

    localparam logic [7:0] GPIO_OFF_OUT       = 8'h00;
    localparam logic [7:0] GPIO_OFF_OE        = 8'h04;
    localparam logic [7:0] GPIO_OFF_IN        = 8'h08;
    localparam logic [7:0] GPIO_OFF_IRQ_EN    = 8'h0C;
    localparam logic [7:0] GPIO_OFF_IRQ_POL   = 8'h10;
    localparam logic [7:0] GPIO_OFF_IRQ_STAT  = 8'h14;
    localparam logic [7:0] GPIO_OFF_PRESCALE  = 8'h18;
    localparam logic [7:0] GPIO_OFF_DUTY_BASE = 8'h20;

    // A peripheral takes a request only while its own ready is low,
    // which forces the idle cycle between back-to-back accesses.
    function automatic logic iomem_select(
        input logic       valid,
        input logic       ready,
        input logic [7:0] addr_hi,
        input logic [7:0] match
    );
        return valid && !ready && (addr_hi == match);
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        return (old & ~strb_mask(wstrb)) | (wdata & strb_mask(wstrb));
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow duty register reloaded at counter wrap
// and a registered compare against the shared counter.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_load,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_cnt,
    output logic                o_pwm
);

    logic [PWM_BITS-1:0] r_shadow;
    logic                r_pwm;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_shadow <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_load) begin
                r_shadow <= i_duty;
            end
            r_pwm <= (i_cnt < r_shadow);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/iomem_gpio_pwm.sv
// iomem GPIO bank with synchronised inputs, edge interrupts and
// per-channel PWM sharing one prescaler and one period counter.
import ricosoc_pkg::*;

module iomem_gpio_pwm #(
    parameter int         GPIO_WIDTH   = 8,
    parameter int         PWM_CHANNELS = 4,
    parameter int         PWM_BITS     = 8,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] ADDR_HI      = 8'h03
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    input  logic [GPIO_WIDTH-1:0]   gpio_in,
    output logic [GPIO_WIDTH-1:0]   gpio_out,
    output logic [GPIO_WIDTH-1:0]   gpio_oe,
    output logic [PWM_CHANNELS-1:0] pwm_out,
    output logic                    irq
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_irq;
    logic [GPIO_WIDTH-1:0] r_out;
    logic [GPIO_WIDTH-1:0] r_oe;
    logic [GPIO_WIDTH-1:0] r_en;
    logic [GPIO_WIDTH-1:0] r_pol;
    logic [GPIO_WIDTH-1:0] r_stat;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
    logic [15:0]           r_prescale;
    logic [15:0]           r_pre;
    logic [PWM_BITS-1:0]   r_cnt;
    logic [PWM_BITS-1:0]   r_duty [PWM_CHANNELS];

    logic                  w_sel;
    logic                  w_wr;
    logic [7:0]            w_off;
    logic                  w_is_duty;
    logic [2:0]            w_idx;
    logic [31:0]           w_rd;
    logic [GPIO_WIDTH-1:0] w_in;
    logic [GPIO_WIDTH-1:0] w_hit;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_unused;

    assign w_sel     = iomem_select(iomem_valid, r_ready,
                                    iomem_addr[31:24], ADDR_HI);
    assign w_wr      = w_sel && (iomem_wstrb != 4'b0000);
    assign w_off     = {iomem_addr[7:2], 2'b00};
    assign w_is_duty = (w_off[7:5] == GPIO_OFF_DUTY_BASE[7:5]);
    assign w_idx     = w_off[4:2];
    assign w_unused  = ^{iomem_addr[23:8], iomem_addr[1:0]};

    // Edges are seen on the last synchroniser stage only.
    assign w_in  = r_sync[SYNC_STAGES-1];
    assign w_hit = (w_in & ~r_prev & r_pol) | (~w_in & r_prev & ~r_pol);
    assign w_w1c = (w_wr && w_off == GPIO_OFF_IRQ_STAT)
                 ? GPIO_WIDTH'(iomem_wdata & strb_mask(iomem_wstrb))
                 : '0;

    assign w_tick = (r_pre == r_prescale);
    assign w_wrap = w_tick && (r_cnt == CNT_LAST);

    always_comb begin
        w_rd = '0;
        case (w_off)
            GPIO_OFF_OUT:      w_rd = 32'(r_out);
            GPIO_OFF_OE:       w_rd = 32'(r_oe);
            GPIO_OFF_IN:       w_rd = 32'(w_in);
            GPIO_OFF_IRQ_EN:   w_rd = 32'(r_en);
            GPIO_OFF_IRQ_POL:  w_rd = 32'(r_pol);
            GPIO_OFF_IRQ_STAT: w_rd = 32'(r_stat);
            GPIO_OFF_PRESCALE: w_rd = 32'(r_prescale);
            default:           w_rd = '0;
        endcase
        if (w_is_duty) begin
            for (int i = 0; i < PWM_CHANNELS; i++) begin
                if (w_idx == 3'(i)) begin
                    w_rd = 32'(r_duty[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
            r_out      <= '0;
            r_oe       <= '0;
            r_en       <= '0;
            r_pol      <= '0;
            r_stat     <= '0;
            r_prev     <= '0;
            r_sync     <= '0;
            r_prescale <= '0;
            r_pre      <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < PWM_CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd : '0;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_prev  <= w_in;
            // A new edge outranks a same-cycle clear.
            r_stat  <= (r_stat & ~w_w1c) | w_hit;
            r_irq   <= |(r_stat & r_en);

            if (w_wr && w_off == GPIO_OFF_PRESCALE) begin
                r_pre <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 16'd1;
            end

            if (w_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + PWM_BITS'(1);
            end

            if (w_wr) begin
                case (w_off)
                    GPIO_OFF_OUT: r_out <= GPIO_WIDTH'(lane_merge(
                        32'(r_out), iomem_wdata, iomem_wstrb));
                    GPIO_OFF_OE: r_oe <= GPIO_WIDTH'(lane_merge(
                        32'(r_oe), iomem_wdata, iomem_wstrb));
                    GPIO_OFF_IRQ_EN: r_en <= GPIO_WIDTH'(lane_merge(
                        32'(r_en), iomem_wdata, iomem_wstrb));
                    GPIO_OFF_IRQ_POL: r_pol <= GPIO_WIDTH'(lane_merge(
                        32'(r_pol), iomem_wdata, iomem_wstrb));
                    GPIO_OFF_PRESCALE: r_prescale <= 16'(lane_merge(
                        32'(r_prescale), iomem_wdata, iomem_wstrb));
                    default: ;
                endcase
                for (int i = 0; i < PWM_CHANNELS; i++) begin
                    if (w_is_duty && w_idx == 3'(i)) begin
                        r_duty[i] <= PWM_BITS'(lane_merge(
                            32'(r_duty[i]), iomem_wdata, iomem_wstrb));
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < PWM_CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .i_clk    (clk),
            .i_resetn (resetn),
            .i_load   (w_wrap),
            .i_duty   (r_duty[g]),
            .i_cnt    (r_cnt),
            .o_pwm    (pwm_out[g])
        );
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign irq         = r_irq;

endmodule

// File: tb/tb_iomem_gpio_pwm.sv
// Randomised bus/GPIO/PWM bench for iomem_gpio_pwm against a
// register-level behavioural model.
module tb_iomem_gpio_pwm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic [3:0]  pwm_out;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_out, m_oe, m_en, m_pol, m_stat, m_pre;
    logic [31:0] m_duty [4];

    always #5 clk = ~clk;

    iomem_gpio_pwm dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .pwm_out     (pwm_out),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0] s,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic m_reset();
        m_out = 0; m_oe = 0; m_en = 0; m_pol = 0; m_stat = 0; m_pre = 0;
        for (int i = 0; i < 4; i++) m_duty[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00: return m_out;
            8'h04: return m_oe;
            8'h08: return 32'(gpio_in);
            8'h0C: return m_en;
            8'h10: return m_pol;
            8'h14: return m_stat;
            8'h18: return m_pre;
            8'h20, 8'h24, 8'h28, 8'h2C: return m_duty[(off - 8'h20) >> 2];
            default: return 0;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] off, input logic [3:0] s,
                           input logic [31:0] d);
        case (off)
            8'h00: m_out = merge(m_out, s, d) & 32'hFF;
            8'h04: m_oe = merge(m_oe, s, d) & 32'hFF;
            8'h0C: m_en = merge(m_en, s, d) & 32'hFF;
            8'h10: m_pol = merge(m_pol, s, d) & 32'hFF;
            8'h14: m_stat = m_stat & ~merge(0, s, d);
            8'h18: m_pre = merge(m_pre, s, d) & 32'hFFFF;
            8'h20, 8'h24, 8'h28, 8'h2C:
                m_duty[(off - 8'h20) >> 2] =
                    merge(m_duty[(off - 8'h20) >> 2], s, d) & 32'hFF;
            default: ;
        endcase
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input int pre,
                       output logic [31:0] rd, output logic got);
        repeat (1 + pre) @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(posedge clk);
        #1;
        got = iomem_ready;
        rd  = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(posedge clk);
        #1;
        chk("ready_drop", 32'(iomem_ready), 0);
    endtask

    task automatic xact(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int pre);
        logic [31:0] rd;
        logic        got;
        logic [31:0] exp;
        exp = m_read(a[7:0] & 8'hFC);
        bus(a, s, d, pre, rd, got);
        chk("ready", 32'(got), 1);
        chk($sformatf("rdata@%02h", a[7:0]), rd, exp);
        m_write(a[7:0] & 8'hFC, s, d);
    endtask

    task automatic count_high(input int ch, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (pwm_out[ch]) hi++;
        end
    endtask

    localparam logic [31:0] BASE = 32'h0300_0000;

    initial begin
        int          hi;
        int          dr;
        int          len;
        int          exp_len;
        logic        cur, prv, inrun, seen200;
        logic [31:0] rd;
        logic        got;
        logic [7:0]  off;
        logic [3:0]  s;

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(iomem_ready), 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_out", 32'(gpio_out), 0);
        chk("rst_oe", 32'(gpio_oe), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int o = 0; o <= 8'h18; o += 4) xact(BASE + 32'(o), 4'b0000, 0, 0);

        xact(BASE + 32'h00, 4'b0001, 32'h0000_00A5, 0);
        xact(BASE + 32'h04, 4'b0001, 32'h0000_00FF, 0);
        chk("out_a5", 32'(gpio_out), 32'hA5);
        chk("oe_ff", 32'(gpio_oe), 32'hFF);
        xact(BASE + 32'h00, 4'b0010, 32'hFFFF_0000, 0);
        chk("out_lane", 32'(gpio_out), 32'hA5);

        gpio_in = 8'($urandom);
        repeat (6) @(posedge clk);
        for (int n = 0; n < 80; n++) begin
            off = 8'($urandom_range(0, 17) * 4);
            s   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            xact({8'h03, 16'($urandom), off}, s, $urandom, 0);
        end
        chk("rnd_out", 32'(gpio_out), m_out);
        chk("rnd_oe", 32'(gpio_oe), m_oe);
        chk("rnd_irq", 32'(irq), 32'(|(m_stat & m_en)));

        gpio_in[3] = 1'b0;
        repeat (6) @(posedge clk);
        xact(BASE + 32'h10, 4'b0001, 32'h08, 0);
        xact(BASE + 32'h0C, 4'b0001, 32'h08, 0);
        xact(BASE + 32'h14, 4'b0001, 32'hFF, 0);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) chk("irq_early", 32'(irq), 0);
            if (k == 4) chk("irq_set", 32'(irq), 1);
        end
        m_stat = m_stat | 32'h08;
        xact(BASE + 32'h14, 4'b0000, 0, 0);
        xact(BASE + 32'h08, 4'b0000, 0, 0);
        xact(BASE + 32'h14, 4'b0001, 32'h08, 0);
        xact(BASE + 32'h14, 4'b0000, 0, 0);
        chk("irq_clr", 32'(irq), 0);

        @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        xact(BASE + 32'h14, 4'b0001, 32'h08, 1);
        m_stat = m_stat | 32'h08;
        xact(BASE + 32'h14, 4'b0000, 0, 0);

        dr = $urandom_range(1, 254);
        xact(BASE + 32'h18, 4'b0011, 0, 0);
        xact(BASE + 32'h20, 4'b0001, 64, 0);
        xact(BASE + 32'h24, 4'b0001, 10, 0);
        xact(BASE + 32'h28, 4'b0001, 32'(dr), 0);
        repeat (600) @(posedge clk);
        count_high(0, 255, hi);
        chk("duty64", 32'(hi), m_duty[0] * (m_pre + 1));
        count_high(2, 255, hi);
        chk("duty_rnd", 32'(hi), m_duty[2] * (m_pre + 1));
        xact(BASE + 32'h20, 4'b0001, 0, 0);
        repeat (600) @(posedge clk);
        count_high(0, 255, hi);
        chk("duty0", 32'(hi), 0);
        xact(BASE + 32'h20, 4'b0001, 255, 0);
        repeat (600) @(posedge clk);
        count_high(0, 255, hi);
        chk("duty255", 32'(hi), 255);

        xact(BASE + 32'h20, 4'b0001, 64, 0);
        xact(BASE + 32'h18, 4'b0011, 1, 0);
        repeat (1100) @(posedge clk);
        count_high(0, 510, hi);
        chk("presc1", 32'(hi), m_duty[0] * (m_pre + 1));

        xact(BASE + 32'h18, 4'b0011, 0, 0);
        repeat (600) @(posedge clk);
        repeat ($urandom_range(0, 254)) @(posedge clk);
        xact(BASE + 32'h24, 4'b0001, 200, 0);
        @(posedge clk);
        #1;
        prv = pwm_out[1];
        inrun = 1'b0;
        seen200 = 1'b0;
        len = 0;
        repeat (800) begin
            @(posedge clk);
            #1;
            cur = pwm_out[1];
            if (cur && !prv) begin
                inrun = 1'b1;
                len = 1;
            end else if (cur && inrun) begin
                len++;
            end else if (!cur && prv && inrun) begin
                inrun = 1'b0;
                exp_len = (seen200 || len == 200) ? 200 : 10;
                chk("pwm_run", 32'(len), 32'(exp_len));
                if (len == 200) seen200 = 1'b1;
            end
            prv = cur;
        end
        chk("pwm_new_duty", 32'(seen200), 1);

        bus(32'h0400_0000, 4'b0000, 0, 0, rd, got);
        chk("no_ack", 32'(got), 0);
        xact(BASE + 32'h40, 4'b0000, 0, 0);
        xact(BASE + 32'h40, 4'b1111, 32'hDEAD_BEEF, 0);
        xact(BASE + 32'h40, 4'b0000, 0, 0);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wstrb = 4'b0001;
        iomem_wdata = 32'h5A;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_sel_ready", 32'(iomem_ready), 0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        resetn      = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_out", 32'(gpio_out), 0);
        chk("rst2_oe", 32'(gpio_oe), 0);
        chk("rst2_pwm", 32'(pwm_out), 0);
        chk("rst2_irq", 32'(irq), 0);
        m_reset();
        xact(BASE + 32'h00, 4'b0000, 0, 0);
        xact(BASE + 32'h20, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iomem_gpio_pwm.md
Name: iomem_gpio_pwm

Overview:
- Parametrised successor to the single-register iomem GPIO on the board tops.
- Provides a multi-register GPIO bank on the ricosoc iomem bus: output data, output enable, synchronised inputs and edge interrupts.
- Adds per-channel 8-bit PWM for the RGB/user LEDs.
- Instantiated in the board top, decoded on address byte ADDR_HI; drives the soc irq_5 input.

Parameters:
- GPIO_WIDTH, 8, number of GPIO pins (1..32).
- PWM_CHANNELS, 4, number of PWM outputs (1..8).
- PWM_BITS, 8, duty/counter resolution (4..16).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- ADDR_HI, 8'h03, value iomem_addr[31:24] must match.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- gpio_in  in  GPIO_WIDTH  asynchronous pin inputs
- gpio_out  out  GPIO_WIDTH  pin output values
- gpio_oe  out  GPIO_WIDTH  pin output enables, 1 = drive
- pwm_out  out  PWM_CHANNELS  PWM waveforms, active high
- irq  out  1  level interrupt

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous, active-low, sampled on posedge clk.
- Reset zeroes all registers and outputs: iomem_ready=0, iomem_rdata=0, gpio_out=0, gpio_oe=0, pwm_out=0, irq=0, and the synchroniser and counters.
- Reset mid-transaction drops ready; the master re-issues after reset.

Bus handshake:
- Select when iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI.
- iomem_ready=1 exactly one cycle after select, then 0 for at least one cycle. Back-to-back accesses therefore take 2 cycles each.
- Writes commit on the select edge, per byte lane.
- Read data is registered on the same edge from pre-write values.

Register map (offset = iomem_addr[7:2]*4):
- Bits at or above GPIO_WIDTH read 0.
- 0x00 OUT RW: gpio_out.
- 0x04 OE RW: gpio_oe.
- 0x08 IN RO: synchronised gpio_in, delayed SYNC_STAGES cycles.
- 0x0C IRQ_EN RW.
- 0x10 IRQ_POL RW: 1 = rising edge, 0 = falling edge.
- 0x14 IRQ_STAT R/W1C.
- 0x18 PRESCALE RW [15:0].
- 0x20+4*i DUTY[i] RW [PWM_BITS-1:0], for i<PWM_CHANNELS.
- Unmapped offsets read 0, ignore writes, and still ack.

Edge detect:
- Compares the last synchroniser stage with its previous value.
- A matching edge sets STAT[n] regardless of EN.
- Same-cycle edge and W1C on a bit: the set wins.
- irq is registered as |(STAT & EN), one cycle after STAT updates.

PWM:
- Prescale counter counts 0..PRESCALE and produces a tick on wrap. PRESCALE=0 gives a tick every cycle.
- The PWM counter advances on each tick over 0..2^PWM_BITS-2 and wraps to 0 (period 2^PWM_BITS-1 ticks).
- Each channel has a shadow duty register, loaded from DUTY[i] when the counter wraps to 0, so duty changes are glitch-free.
- pwm_out[i] = (cnt < shadow[i]), registered.
  - Duty 0: constantly low.
  - Duty 2^PWM_BITS-1: constantly high.
- A PRESCALE write resets the prescale counter to 0.

Decomposition:
- Shared package ricosoc_pkg holds:
  - register offset constants: GPIO_OFF_OUT, _OE, _IN, _IRQ_EN, _IRQ_POL, _IRQ_STAT, _PRESCALE, _DUTY_BASE;
  - the iomem ready/select helper convention.
- One sub-module, pwm_channel: shadow duty register plus comparator. Instantiated PWM_CHANNELS times, sharing the counter and tick from the parent.

Test Plan:
- Reset, then read 0x03000000..0x03000018: all reads 0. iomem_ready high exactly one cycle after each select and low the next.
- Write 0x000000A5 to OUT with wstrb=4'b0001, then 0x000000FF to OE. Required: gpio_out=0xA5, gpio_oe=0xFF. A wstrb=4'b0010 write of 0xFFFF0000 leaves OUT=0xA5.
- gpio_in[3] rising with POL[3]=1, EN[3]=1: STAT=0x08 after SYNC_STAGES+1 cycles, irq=1 one cycle later. W1C 0x08 clears it. A W1C coinciding with a new edge leaves STAT[3]=1.
- PRESCALE=0, DUTY[0]=64, PWM_BITS=8: pwm_out[0] high for 64 of every 255 cycles. DUTY=0 gives constant low; DUTY=255 gives constant high.
- DUTY[1] changed mid-period from 10 to 200: the old duty holds until the counter wraps, then the new duty applies. No runt pulse.
- Access to 0x04000000: no ready. Access to unmapped offset 0x03000040: ready, reads 0. Reset asserted during a pending select: ready stays 0 and registers are cleared.
